hdmi_video_timing: RTL and testbench
====================================

// Module: hdmi_video_timing
// PURPOSE
//  Raster timing generator clocked by the HDMI PLL pixel clock (clkout0).
//  Waits for PLL lock to stay stable, then produces hsync/vsync/de and pixel
//  coordinates for the downstream pixel fetch and TMDS encoder.
//  Lock loss blanks the raster at once; lock recovery restarts it at pixel (0,0).
// PARAMETERS
//  H_ACTIVE 1280  visible pixels/line     | H_FP 110 | H_SYNC 40 | H_BP 220
//  V_ACTIVE 720   visible lines/frame     | V_FP 5   | V_SYNC 5  | V_BP 20
//  HS_POL   1     1 = hsync active-high   | VS_POL 1 = vsync active-high
//  SETTLE   1024  clk cycles lock must hold before raster starts (>=1)
//  XW 11, YW 10   coordinate widths; must hold H_TOTAL-1 / V_TOTAL-1
// PORTS
//  clk          in   1   pixel clock (PLL clkout0)
//  rst_n        in   1   asynchronous active-low reset
//  pll_lock     in   1   PLL lock, asynchronous to clk
//  hsync        out  1   horizontal sync, polarity HS_POL
//  vsync        out  1   vertical sync, polarity VS_POL
//  de           out  1   data enable, high in the active area
//  x            out  XW  column, valid while de
//  y            out  YW  line, valid while de
//  frame_start  out  1   one-cycle pulse with pixel (0,0)
//  line_start   out  1   one-cycle pulse with x==0 on every active line
//  running      out  1   high in RUN
// BEHAVIOUR
//  Reset state: all outputs 0 except hsync=!HS_POL, vsync=!VS_POL (inactive).
//  pll_lock passes through a 2-flop synchroniser; lock_s below is its output.
//  H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (1650). V_TOTAL likewise (750).
//  FSM states:
//   WAIT_LOCK : counters held at 0, outputs inactive. lock_s=1 -> SETTLE,
//               settle counter cleared.
//   SETTLE    : count while lock_s=1. lock_s=0 -> WAIT_LOCK.
//               Count reaches SETTLE-1 -> RUN, hcnt=vcnt=0.
//   RUN       : raster counting. lock_s=0 -> WAIT_LOCK on the next edge.
//               Outputs go inactive on that edge, mid-line or mid-frame.
//  Counters in RUN: hcnt 0..H_TOTAL-1 wraps to 0. vcnt increments at each
//   hcnt wrap and wraps 0 after V_TOTAL-1. No other way out of range.
//  Region order per line/frame: active, front porch, sync, back porch.
//   hs_i = hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
//   vs_i = vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC); vsync edges align to hcnt==0
//   de_i = hcnt<H_ACTIVE && vcnt<V_ACTIVE
//  All outputs registered: latency 1 clk from counter state to ports.
//   hsync/vsync/de/x/y/frame_start/line_start stay mutually aligned.
//  x/y = hcnt/vcnt when de, else 0.
//  frame_start = (hcnt==0 && vcnt==0), registered.
//  line_start  = (hcnt==0 && vcnt<V_ACTIVE), registered.
//  First RUN cycle: outputs show (0,0) one clk later, with frame_start=1.
//  Lock glitch shorter than the synchroniser delay is not filtered.
//   Any lock_s low cycle restarts SETTLE fully.
//  rst_n assert mid-frame: immediate inactive outputs, FSM to WAIT_LOCK.
// STRUCTURE
//  Package hdmi_pkg: FSM state encoding (WAIT_LOCK=0, SETTLE=1, RUN=2).
//   Also 720p timing constants as the defaults shared with TMDS/fetch blocks.
//  Sub-module hdmi_lock_filter: 2-flop sync plus SETTLE counter.
//   Outputs lock_ok, high while lock held >= SETTLE cycles.
//  Top module: FSM, h/v counters, output registers.
// TESTING (small params: H 8/2/2/2, V 4/1/1/1, SETTLE 4 -> H_TOTAL 14, V_TOTAL 7)
//  1 rst_n=0, pll_lock=1 -> all outputs at reset values. Release rst_n:
//    running=1 after 2 sync + 4 settle cycles; frame_start 1 clk later with x=0,y=0,de=1.
//  2 Run 2 full frames -> exactly 8 de cycles/line, 4 active lines/frame.
//    98 clk between frame_starts; hsync high clk 10-11 of each line.
//  3 vsync (VS_POL=1) -> high for exactly 14 clk (line 5), rising at hcnt 0 output.
//    x,y = 0 whenever de=0.
//  4 Drop pll_lock for 1 clk at line 2, x=3 -> de/running fall within 3 clk.
//    Restart after full SETTLE from (0,0) with frame_start.
//  5 Lock toggling 1,1,0,1,1,0 during SETTLE -> running never rises.
//  6 HS_POL=0, VS_POL=0 -> sync outputs inverted, reset values 1, de timing unchanged.

Source files
------------

// File: rtl/hdmi_pkg.sv
// hdmi_pkg: raster FSM encoding and 720p timing defaults shared by the video pipeline
package hdmi_pkg;

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_SETTLE    = 2'd1,
        S_RUN       = 2'd2
    } state_t;

    localparam int H_ACTIVE_720P = 1280;
    localparam int H_FP_720P     = 110;
    localparam int H_SYNC_720P   = 40;
    localparam int H_BP_720P     = 220;
    localparam int V_ACTIVE_720P = 720;
    localparam int V_FP_720P     = 5;
    localparam int V_SYNC_720P   = 5;
    localparam int V_BP_720P     = 20;
    localparam int SETTLE_720P   = 1024;
    localparam int XW_720P       = 11;
    localparam int YW_720P       = 10;

    function automatic logic sync_level(input logic on, input logic pol);
        return on ? pol : ~pol;
    endfunction

endpackage

// File: rtl/hdmi_lock_filter.sv
// hdmi_lock_filter: synchronises PLL lock and reports when it has held long enough
module hdmi_lock_filter
    import hdmi_pkg::*;
#(
    parameter int SETTLE = SETTLE_720P
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pll_lock,
    output logic lock_s,
    output logic lock_ok
);

    localparam int CW = $clog2(SETTLE + 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;

    // two-flop synchroniser for the asynchronous lock input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sync <= '0;
        else        r_sync <= {r_sync[0], pll_lock};
    end

    assign lock_s = r_sync[1];

    // consecutive synchronised-lock cycles; any low cycle restarts the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cnt <= '0;
        else        r_cnt <= !lock_s ? '0 : (r_cnt == CW'(SETTLE - 1)) ? r_cnt : r_cnt + CW'(1);
    end

    assign lock_ok = lock_s && (r_cnt == CW'(SETTLE - 1));

endmodule

// File: rtl/hdmi_video_timing.sv
// hdmi_video_timing: lock-gated raster timing generator for the HDMI pixel clock domain
module hdmi_video_timing
    import hdmi_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_720P,
    parameter int H_FP     = H_FP_720P,
    parameter int H_SYNC   = H_SYNC_720P,
    parameter int H_BP     = H_BP_720P,
    parameter int V_ACTIVE = V_ACTIVE_720P,
    parameter int V_FP     = V_FP_720P,
    parameter int V_SYNC   = V_SYNC_720P,
    parameter int V_BP     = V_BP_720P,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int SETTLE   = SETTLE_720P,
    parameter int XW       = XW_720P,
    parameter int YW       = YW_720P
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pll_lock,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          frame_start,
    output logic          line_start,
    output logic          running
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    state_t        r_state;
    state_t        w_next;
    logic [XW-1:0] r_hcnt;
    logic [YW-1:0] r_vcnt;
    logic          w_lock_s;
    logic          w_lock_ok;
    logic          w_adv;
    logic          w_h_wrap;
    logic          w_v_wrap;
    logic          w_hs;
    logic          w_vs;
    logic          w_de;

    hdmi_lock_filter #(
        .SETTLE(SETTLE)
    ) u_lock (
        .clk     (clk),
        .rst_n   (rst_n),
        .pll_lock(pll_lock),
        .lock_s  (w_lock_s),
        .lock_ok (w_lock_ok)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_WAIT_LOCK;
        else        r_state <= w_next;
    end

    // next state: any synchronised lock loss drops straight back to waiting
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_WAIT_LOCK: w_next = w_lock_s ? S_SETTLE : S_WAIT_LOCK;
            S_SETTLE:    w_next = !w_lock_s ? S_WAIT_LOCK : w_lock_ok ? S_RUN : S_SETTLE;
            S_RUN:       w_next = w_lock_s ? S_RUN : S_WAIT_LOCK;
            default:     w_next = S_WAIT_LOCK;
        endcase
    end

    assign running  = (r_state == S_RUN);
    assign w_adv    = running && w_lock_s;
    assign w_h_wrap = (r_hcnt == XW'(H_TOTAL - 1));
    assign w_v_wrap = (r_vcnt == YW'(V_TOTAL - 1));

    // raster counters, held at the origin whenever the raster is not advancing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (!w_adv) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else begin
            r_hcnt <= w_h_wrap ? '0 : r_hcnt + XW'(1);
            r_vcnt <= !w_h_wrap ? r_vcnt : w_v_wrap ? '0 : r_vcnt + YW'(1);
        end
    end

    assign w_hs = (r_hcnt >= XW'(H_ACTIVE + H_FP)) && (r_hcnt < XW'(H_ACTIVE + H_FP + H_SYNC));
    assign w_vs = (r_vcnt >= YW'(V_ACTIVE + V_FP)) && (r_vcnt < YW'(V_ACTIVE + V_FP + V_SYNC));
    assign w_de = (r_hcnt < XW'(H_ACTIVE)) && (r_vcnt < YW'(V_ACTIVE));

    // output registers; going inactive on the same edge the raster stops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else begin
            hsync       <= sync_level(w_adv && w_hs, HS_POL);
            vsync       <= sync_level(w_adv && w_vs, VS_POL);
            de          <= w_adv && w_de;
            x           <= (w_adv && w_de) ? r_hcnt : '0;
            y           <= (w_adv && w_de) ? r_vcnt : '0;
            frame_start <= w_adv && (r_hcnt == '0) && (r_vcnt == '0);
            line_start  <= w_adv && (r_hcnt == '0) && (r_vcnt < YW'(V_ACTIVE));
        end
    end

endmodule

// File: tb/tb_hdmi_video_timing.sv
// tb_hdmi_video_timing: randomized and directed checks of the raster generator against a pixel-index model
module tb_hdmi_video_timing;

    localparam int HT  = 14;
    localparam int VT  = 7;
    localparam int SET = 4;
    localparam logic [12:0] RST1 = 13'd0;
    localparam logic [12:0] RST2 = {4'b0011, 9'd0};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_lock = 1'b1;
    logic       hs1, vs1, de1, fs1, ls1, run1;
    logic       hs2, vs2, de2, fs2, ls2, run2;
    logic [3:0] x1, x2;
    logic [2:0] y1, y2;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    hdmi_video_timing #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .SETTLE(SET), .XW(4), .YW(3)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock),
        .hsync(hs1), .vsync(vs1), .de(de1), .x(x1), .y(y1),
        .frame_start(fs1), .line_start(ls1), .running(run1)
    );

    hdmi_video_timing #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .SETTLE(SET), .XW(4), .YW(3)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock),
        .hsync(hs2), .vsync(vs2), .de(de2), .x(x2), .y(y2),
        .frame_start(fs2), .line_start(ls2), .running(run2)
    );

    // reference: raster runs once synchronised lock has held SET cycles; position is an index since start
    logic m_l1, m_l2, m_run, e_act;
    int   m_streak, m_age, e_h, e_v;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_l1 <= 0; m_l2 <= 0; m_streak <= 0; m_run <= 0; m_age <= 0;
            e_act <= 0; e_h <= 0; e_v <= 0;
        end else begin
            m_l1     <= pll_lock;
            m_l2     <= m_l1;
            m_streak <= m_l2 ? m_streak + 1 : 0;
            m_run    <= m_l2 && (m_streak + 1 >= SET);
            m_age    <= (m_l2 && (m_streak + 1 >= SET)) ? m_age + 1 : 0;
            e_act    <= m_run && m_l2 && (m_streak + 1 >= SET);
            e_h      <= (m_age > 0) ? (m_age - 1) % HT : 0;
            e_v      <= (m_age > 0) ? ((m_age - 1) / HT) % VT : 0;
        end
    end

    logic        e_de, e_hs, e_vs, e_fs, e_ls;
    logic [12:0] exp1, exp2, got1, got2;

    always_comb begin
        e_de = e_act && e_h < 8 && e_v < 4;
        e_hs = e_act && e_h >= 10 && e_h < 12;
        e_vs = e_act && e_v == 5;
        e_fs = e_act && e_h == 0 && e_v == 0;
        e_ls = e_act && e_h == 0 && e_v < 4;
        exp1 = {m_run, e_de, e_hs, e_vs, e_fs, e_ls, e_de ? 4'(e_h) : 4'd0, e_de ? 3'(e_v) : 3'd0};
        exp2 = {m_run, e_de, !e_hs, !e_vs, e_fs, e_ls, e_de ? 4'(e_h) : 4'd0, e_de ? 3'(e_v) : 3'd0};
    end

    assign got1 = {run1, de1, hs1, vs1, fs1, ls1, x1, y1};
    assign got2 = {run2, de2, hs2, vs2, fs2, ls2, x2, y2};

    task automatic test_reset();
        rst_n = 0;
        pll_lock = 1;
        repeat (3) @(negedge clk);
        total += 2;
        if (got1 !== RST1) begin bad++; $display("FAIL reset_dut1 got=%b exp=%b", got1, RST1); end
        if (got2 !== RST2) begin bad++; $display("FAIL reset_dut2 got=%b exp=%b", got2, RST2); end
        rst_n = 1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            total += 3;
            if (run1 !== (c >= 6)) begin bad++; $display("FAIL start_running cyc=%0d got=%b", c, run1); end
            if (got1 !== exp1) begin bad++; $display("FAIL start_dut1 got=%b exp=%b", got1, exp1); end
            if (got2 !== exp2) begin bad++; $display("FAIL start_dut2 got=%b exp=%b", got2, exp2); end
            if (c == 7) begin
                total++;
                if ({fs1, de1, x1, y1} !== 9'b1_1_0000_000)
                    begin bad++; $display("FAIL first_pixel got fs/de/x/y=%b", {fs1, de1, x1, y1}); end
            end
        end
    endtask

    task automatic test_frames();
        int n = 0, de_cnt = 0, hs_cnt = 0, ls_cnt = 0, fs_at = -1;
        while (!fs1 && n < 200) begin @(negedge clk); n++; end
        total++;
        if (fs1 !== 1'b1) begin bad++; $display("FAIL frames_wait got fs=%b exp=1", fs1); end
        for (int i = 0; i < 2 * HT * VT; i++) begin
            total += 3;
            if (got1 !== exp1) begin bad++; $display("FAIL frames_dut1 got=%b exp=%b", got1, exp1); end
            if (got2 !== exp2) begin bad++; $display("FAIL frames_dut2 got=%b exp=%b", got2, exp2); end
            if (hs1 !== ((i % HT) >= 10 && (i % HT) < 12))
                begin bad++; $display("FAIL hsync_pos i=%0d got=%b", i, hs1); end
            de_cnt += int'(de1);
            hs_cnt += int'(hs1);
            ls_cnt += int'(ls1);
            if (i > 0 && fs1 && fs_at < 0) fs_at = i;
            @(negedge clk);
        end
        total += 5;
        if (de_cnt != 64) begin bad++; $display("FAIL de_count got=%0d exp=64", de_cnt); end
        if (hs_cnt != 28) begin bad++; $display("FAIL hs_count got=%0d exp=28", hs_cnt); end
        if (ls_cnt != 8) begin bad++; $display("FAIL ls_count got=%0d exp=8", ls_cnt); end
        if (fs_at != 98) begin bad++; $display("FAIL fs_period got=%0d exp=98", fs_at); end
        if (fs1 !== 1'b1) begin bad++; $display("FAIL fs_third got=%b exp=1", fs1); end
    endtask

    task automatic test_vsync();
        int first = -1, last = -1, cnt = 0;
        for (int i = 0; i < HT * VT; i++) begin
            total += 3;
            if (got1 !== exp1) begin bad++; $display("FAIL vsync_dut1 got=%b exp=%b", got1, exp1); end
            if (got2 !== exp2) begin bad++; $display("FAIL vsync_dut2 got=%b exp=%b", got2, exp2); end
            if (!de1 && {x1, y1} !== 7'd0) begin bad++; $display("FAIL xy_blank got=%b exp=0", {x1, y1}); end
            if (vs1) begin cnt++; last = i; if (first < 0) first = i; end
            @(negedge clk);
        end
        total += 3;
        if (first != 70) begin bad++; $display("FAIL vsync_rise got=%0d exp=70", first); end
        if (last != 83) begin bad++; $display("FAIL vsync_fall got=%0d exp=83", last); end
        if (cnt != 14) begin bad++; $display("FAIL vsync_len got=%0d exp=14", cnt); end
    endtask

    task automatic test_lock_drop();
        int n = 0, fall = -1, fs_k = -1;
        while (!(de1 && x1 == 4'd3 && y1 == 3'd2) && n < 200) begin @(negedge clk); n++; end
        total++;
        if ({de1, x1, y1} !== {1'b1, 4'd3, 3'd2}) begin bad++; $display("FAIL drop_wait got=%b", {de1, x1, y1}); end
        pll_lock = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 1) pll_lock = 1;
            total += 2;
            if (got1 !== exp1) begin bad++; $display("FAIL drop_dut1 got=%b exp=%b", got1, exp1); end
            if (got2 !== exp2) begin bad++; $display("FAIL drop_dut2 got=%b exp=%b", got2, exp2); end
            if (fall < 0 && !run1 && !de1) fall = k;
            if (fs_k < 0 && fs1) fs_k = k;
        end
        total += 2;
        if (fall != 3) begin bad++; $display("FAIL drop_fall got=%0d exp=3", fall); end
        if (fs_k != 8) begin bad++; $display("FAIL drop_restart got=%0d exp=8", fs_k); end
    endtask

    task automatic test_settle_glitch();
        logic [5:0] pat = 6'b110110;
        pll_lock = 0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 18; i++) begin
            pll_lock = (i < 6) ? pat[5 - i] : 1'b0;
            @(negedge clk);
            total += 3;
            if (run1 !== 1'b0 || run2 !== 1'b0) begin bad++; $display("FAIL glitch_run i=%0d got=%b%b exp=00", i, run1, run2); end
            if (got1 !== exp1) begin bad++; $display("FAIL glitch_dut1 got=%b exp=%b", got1, exp1); end
            if (got2 !== exp2) begin bad++; $display("FAIL glitch_dut2 got=%b exp=%b", got2, exp2); end
        end
        pll_lock = 1;
    endtask

    task automatic test_random();
        int lo = 0;
        for (int i = 0; i < 1500; i++) begin
            if (lo > 0) begin lo--; pll_lock = 0; end
            else if ($urandom_range(0, 199) == 0) begin lo = $urandom_range(0, 7); pll_lock = 0; end
            else pll_lock = 1;
            @(negedge clk);
            total += 2;
            if (got1 !== exp1) begin bad++; $display("FAIL rand_dut1 i=%0d got=%b exp=%b", i, got1, exp1); end
            if (got2 !== exp2) begin bad++; $display("FAIL rand_dut2 i=%0d got=%b exp=%b", i, got2, exp2); end
        end
        pll_lock = 1;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        while (!(de1 && y1 == 3'd1) && n < 400) begin @(negedge clk); n++; end
        total++;
        if ({de1, y1} !== 4'b1_001) begin bad++; $display("FAIL rmid_wait got=%b", {de1, y1}); end
        rst_n = 0;
        #1;
        total += 2;
        if (got1 !== RST1) begin bad++; $display("FAIL rmid_dut1 got=%b exp=%b", got1, RST1); end
        if (got2 !== RST2) begin bad++; $display("FAIL rmid_dut2 got=%b exp=%b", got2, RST2); end
        @(negedge clk);
        rst_n = 1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            total += 2;
            if (got1 !== exp1) begin bad++; $display("FAIL rmid_run1 got=%b exp=%b", got1, exp1); end
            if (run1 !== (c >= 6)) begin bad++; $display("FAIL rmid_running c=%0d got=%b", c, run1); end
        end
    endtask

    task automatic test_polarity();
        int n = 0, hs_lo = 0, vs_lo = 0;
        while (!fs2 && n < 200) begin @(negedge clk); n++; end
        total++;
        if (fs2 !== 1'b1) begin bad++; $display("FAIL pol_wait got fs=%b exp=1", fs2); end
        for (int i = 0; i < HT * VT; i++) begin
            total++;
            if (got2 !== exp2) begin bad++; $display("FAIL pol_dut2 got=%b exp=%b", got2, exp2); end
            hs_lo += int'(!hs2);
            vs_lo += int'(!vs2);
            @(negedge clk);
        end
        total += 2;
        if (hs_lo != 14) begin bad++; $display("FAIL pol_hs_low got=%0d exp=14", hs_lo); end
        if (vs_lo != 14) begin bad++; $display("FAIL pol_vs_low got=%0d exp=14", vs_lo); end
    endtask

    initial begin
        test_reset();
        test_frames();
        test_vsync();
        test_lock_drop();
        test_settle_glitch();
        test_random();
        test_reset_mid();
        test_polarity();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
